// File: rtl/button_event_scheduler.sv
// Converts debounced active-low button levels into typed events (press/release/long/repeat),
// arbitrated round-robin into a valid/ready event FIFO. Optional auto-repeat: AUTO_REPEAT_EN.
module button_event_scheduler #(
    parameter int NUM_BTN       = 5,
    parameter int IDX_W         = 3,
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_db,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [IDX_W-1:0]   ev_idx,
    output logic [1:0]         ev_type,
    output logic               ev_overflow,
    output logic               any_held
);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam int             ENT_W    = IDX_W + 2;
    localparam logic [31:0]    LONG_C   = 32'(LONG_CYCLES);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    if (NUM_BTN < 1 || NUM_BTN > 8 || IDX_W < $clog2(NUM_BTN) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_event_scheduler: illegal parameter set");
    end

    logic [NUM_BTN-1:0] prev_q, prev_d;
    logic [31:0]        hold_q [NUM_BTN];
    logic [31:0]        hold_d [NUM_BTN];
    logic [3:0]         pend_q [NUM_BTN];
    logic [3:0]         pend_d [NUM_BTN];
    logic [3:0]         set_ev [NUM_BTN];
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic               ovf_q, ovf_d, held_q, held_d;
    logic               pop, push, found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [3:0]         gnt_pend, gnt_mask;
    logic [1:0]         gnt_type;
    logic [ENT_W-1:0]   head;
`ifdef AUTO_REPEAT_EN
    localparam logic [31:0] REP_C = 32'(REPEAT_CYCLES);
    logic [31:0]        rep_q [NUM_BTN];
    logic [31:0]        rep_d [NUM_BTN];
`endif

    // Event sources: bit 0 press, 1 release, 2 long, 3 repeat
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            set_ev[i]    = 4'b0000;
            set_ev[i][0] = prev_q[i] & ~btn_db[i];
            set_ev[i][1] = ~prev_q[i] & btn_db[i];
            set_ev[i][2] = ~btn_db[i] & (hold_q[i] == LONG_C);
            if (btn_db[i])        hold_d[i] = '0;
            else if (&hold_q[i])  hold_d[i] = hold_q[i];
            else                  hold_d[i] = hold_q[i] + 32'd1;
`ifdef AUTO_REPEAT_EN
            // Repeat timer is loaded on the long event and reloads on each expiry
            rep_d[i] = '0;
            if (!btn_db[i] && hold_q[i] == LONG_C) begin
                rep_d[i] = REP_C;
            end else if (!btn_db[i] && hold_q[i] > LONG_C) begin
                if (rep_q[i] == 32'd1) begin
                    set_ev[i][3] = 1'b1;
                    rep_d[i]     = REP_C;
                end else begin
                    rep_d[i] = rep_q[i] - 32'd1;
                end
            end
`endif
        end
        prev_d = btn_db;
        held_d = ~&btn_db;
    end

    assign ev_valid = (cnt_q != '0);
    assign pop      = ev_valid & ev_ready;

    // Round-robin: second pass (indices above rr_q) overrides the wrapped first pass
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_pend = 4'b0000;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (|pend_q[i] && i <= int'(rr_q)) begin
                found    = 1'b1;
                gnt_idx  = IDX_W'(i);
                gnt_pend = pend_q[i];
            end
        end
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (|pend_q[i] && i > int'(rr_q)) begin
                found    = 1'b1;
                gnt_idx  = IDX_W'(i);
                gnt_pend = pend_q[i];
            end
        end
        gnt_type = 2'd0;
        if (!gnt_pend[0]) begin
            if (gnt_pend[1])      gnt_type = 2'd1;
            else if (gnt_pend[2]) gnt_type = 2'd2;
            else if (gnt_pend[3]) gnt_type = 2'd3;
        end
        gnt_mask = 4'b0001 << gnt_type;
        push     = found & ((cnt_q != FULL_CNT) | pop);
        rr_d     = push ? gnt_idx : rr_q;
    end

    always_comb begin
        ovf_d = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pend_d[i] = pend_q[i];
            if (push && gnt_idx == IDX_W'(i)) pend_d[i] = pend_q[i] & ~gnt_mask;
            if (|(pend_d[i] & set_ev[i])) ovf_d = 1'b1;
            pend_d[i] = pend_d[i] | set_ev[i];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {gnt_idx, gnt_type};
        wr_d  = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    assign head        = mem_q[rd_q];
    assign ev_idx      = ev_valid ? head[ENT_W-1:2] : '0;
    assign ev_type     = ev_valid ? head[1:0] : 2'b00;
    assign ev_overflow = ovf_q;
    assign any_held    = held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '1;
            rr_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            held_q <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_q[i] <= '0;
                pend_q[i] <= '0;
`ifdef AUTO_REPEAT_EN
                rep_q[i]  <= '0;
`endif
            end
            for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
        end else begin
            prev_q <= prev_d;
            rr_q   <= rr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            held_q <= held_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_q[i] <= hold_d[i];
                pend_q[i] <= pend_d[i];
`ifdef AUTO_REPEAT_EN
                rep_q[i]  <= rep_d[i];
`endif
            end
            for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= mem_d[j];
        end
    end
endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus randomized traffic checked
// against a queue-based event model.
module tb_button_event_scheduler;
    localparam int NB = 5;
    localparam int IW = 3;
    localparam int LC = 20;
    localparam int RC = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_db = '1;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [IW-1:0] ev_idx;
    logic [1:0]    ev_type;
    logic          ev_overflow;
    logic          any_held;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_event_scheduler #(
        .NUM_BTN(NB), .IDX_W(IW), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_db(btn_db), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_idx(ev_idx), .ev_type(ev_type), .ev_overflow(ev_overflow), .any_held(any_held)
    );

    // Reference model: per-button pending sets, hold length in cycles, event queue
    logic [NB-1:0] m_prev;
    int            m_hold [NB];
    logic [3:0]    m_pend [NB];
    logic [4:0]    m_fifo [$];
    int            m_rr;
    logic          m_ovf;
    logic          m_any;

    task automatic model_reset();
        m_prev = '1;
        for (int b = 0; b < NB; b++) begin
            m_hold[b] = 0;
            m_pend[b] = 4'b0;
        end
        m_fifo.delete();
        m_rr  = 0;
        m_ovf = 1'b0;
        m_any = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int gt;
        logic ovf;
        logic [3:0] s;
        g   = -1;
        gt  = 0;
        ovf = 1'b0;
        if (m_fifo.size() != 0 && ev_ready) void'(m_fifo.pop_front());
        if (m_fifo.size() < FD) begin
            for (int k = 1; k <= NB; k++) begin
                int b;
                b = (m_rr + k) % NB;
                if (g < 0 && m_pend[b] != 4'b0) g = b;
            end
        end
        if (g >= 0) begin
            gt = m_pend[g][0] ? 0 : m_pend[g][1] ? 1 : m_pend[g][2] ? 2 : 3;
            m_pend[g][gt] = 1'b0;
            m_fifo.push_back(5'(g * 4 + gt));
            m_rr = g;
        end
        for (int b = 0; b < NB; b++) begin
            s    = 4'b0;
            s[0] = m_prev[b] && !btn_db[b];
            s[1] = !m_prev[b] && btn_db[b];
            s[2] = !btn_db[b] && m_hold[b] == LC;
`ifdef AUTO_REPEAT_EN
            s[3] = !btn_db[b] && m_hold[b] > LC && ((m_hold[b] - LC) % RC) == 0;
`endif
            if ((s & m_pend[b]) != 4'b0) ovf = 1'b1;
            m_pend[b] = m_pend[b] | s;
            m_hold[b] = btn_db[b] ? 0 : m_hold[b] + 1;
        end
        m_prev = btn_db;
        m_ovf  = ovf;
        m_any  = ~&btn_db;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_db = '1; ev_ready = 1'b0;
        wait_cyc(3);
        checks++; if (ev_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b exp 0", ev_valid); end
        checks++; if (ev_idx !== 3'd0)      begin errors++; $display("FAIL reset_idx got %0d exp 0", ev_idx); end
        checks++; if (ev_type !== 2'd0)     begin errors++; $display("FAIL reset_type got %0d exp 0", ev_type); end
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ev_overflow); end
        checks++; if (any_held !== 1'b0)    begin errors++; $display("FAIL reset_held got %b exp 0", any_held); end
        rst_n = 1'b1;
        wait_cyc(4);
        checks++; if (ev_valid !== 1'b0)    begin errors++; $display("FAIL idle_valid got %b exp 0", ev_valid); end
    endtask

    task automatic test_press_release();
        ev_ready = 1'b1;
        btn_db[2] = 1'b0;
        wait_cyc(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL press_lat1 valid got %b exp 0", ev_valid); end
        checks++; if (any_held !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", any_held); end
        wait_cyc(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 3'd2 || ev_type !== 2'd0) begin
            errors++; $display("FAIL press_event got v%b idx%0d t%0d exp v1 idx2 t0", ev_valid, ev_idx, ev_type);
        end
        wait_cyc(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL press_popped valid got %b exp 0", ev_valid); end
        btn_db[2] = 1'b1;
        wait_cyc(2);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 3'd2 || ev_type !== 2'd1) begin
            errors++; $display("FAIL release_event got v%b idx%0d t%0d exp v1 idx2 t1", ev_valid, ev_idx, ev_type);
        end
        checks++; if (any_held !== 1'b0) begin errors++; $display("FAIL release_held got %b exp 0", any_held); end
        wait_cyc(3);
    endtask

    task automatic test_round_robin();
        ev_ready = 1'b1;
        btn_db[0] = 1'b0; wait_cyc(3);
        btn_db[0] = 1'b1; wait_cyc(4);
        btn_db[0] = 1'b0; btn_db[3] = 1'b0;
        wait_cyc(2);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 3'd3 || ev_type !== 2'd0) begin
            errors++; $display("FAIL rr_first got v%b idx%0d t%0d exp v1 idx3 t0", ev_valid, ev_idx, ev_type);
        end
        wait_cyc(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_idx !== 3'd0 || ev_type !== 2'd0) begin
            errors++; $display("FAIL rr_second got v%b idx%0d t%0d exp v1 idx0 t0", ev_valid, ev_idx, ev_type);
        end
        wait_cyc(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_drained valid got %b exp 0", ev_valid); end
        btn_db[0] = 1'b1; btn_db[3] = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq [6];
        logic [4:0] got [$];
        int n_ovf;
        int n_unstable;
        exp_seq = '{5'b001_00, 5'b010_00, 5'b100_00, 5'b001_01, 5'b010_01, 5'b100_01};
        n_ovf = 0; n_unstable = 0;
        ev_ready = 1'b0;
        btn_db[1] = 1'b0; btn_db[2] = 1'b0; btn_db[4] = 1'b0;
        wait_cyc(3);
        btn_db[1] = 1'b1; btn_db[2] = 1'b1; btn_db[4] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            wait_cyc(1);
            if (ev_overflow !== 1'b0) n_ovf++;
            if (ev_valid !== 1'b1 || ev_idx !== 3'd1 || ev_type !== 2'd0) n_unstable++;
        end
        checks++; if (n_ovf != 0)      begin errors++; $display("FAIL b2b_no_ovf got %0d pulses exp 0", n_ovf); end
        checks++; if (n_unstable != 0) begin errors++; $display("FAIL b2b_head_stable got %0d bad cycles exp 0", n_unstable); end
        ev_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (ev_valid === 1'b1) got.push_back({ev_idx, ev_type});
            wait_cyc(1);
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got.size()); end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_seq[k]) begin
                errors++; $display("FAIL b2b_order[%0d] got %b exp %b", k, got[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_overflow();
        int n_ovf;
        int n_p1;
        int n_tot;
        n_ovf = 0; n_p1 = 0; n_tot = 0;
        ev_ready = 1'b0;
        btn_db[2] = 1'b0; btn_db[3] = 1'b0;
        wait_cyc(2);
        btn_db[2] = 1'b1; btn_db[3] = 1'b1;
        wait_cyc(5);
        checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_quiet got %b exp 0", ev_overflow); end
        for (int c = 0; c < 6; c++) begin
            if (c == 0) btn_db[1] = 1'b0;
            if (c == 1) btn_db[1] = 1'b1;
            if (c == 2) btn_db[1] = 1'b0;
            wait_cyc(1);
            if (ev_overflow === 1'b1) n_ovf++;
        end
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL ovf_pulses got %0d exp 1", n_ovf); end
        ev_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ev_valid === 1'b1) begin
                n_tot++;
                if (ev_idx == 3'd1 && ev_type == 2'd0) n_p1++;
            end
            wait_cyc(1);
        end
        checks++; if (n_p1 != 1)  begin errors++; $display("FAIL ovf_single_press got %0d exp 1", n_p1); end
        checks++; if (n_tot != 6) begin errors++; $display("FAIL ovf_total got %0d exp 6", n_tot); end
        btn_db[1] = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_long_hold();
        int c_press, c_long, c_rep, n_press, n_long, n_rep, n_rel;
        c_press = -1; c_long = -1; c_rep = -1; n_press = 0; n_long = 0; n_rep = 0; n_rel = 0;
        ev_ready = 1'b1;
        btn_db[4] = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            wait_cyc(1);
            if (ev_valid === 1'b1 && ev_idx == 3'd4) begin
                case (ev_type)
                    2'd0: begin n_press++; c_press = c; end
                    2'd1: n_rel++;
                    2'd2: begin n_long++; c_long = c; end
                    default: begin n_rep++; if (c_rep < 0) c_rep = c; end
                endcase
            end
            if (c == 30) btn_db[4] = 1'b1;
        end
        checks++; if (n_press != 1) begin errors++; $display("FAIL long_press_count got %0d exp 1", n_press); end
        checks++; if (n_long != 1)  begin errors++; $display("FAIL long_count got %0d exp 1", n_long); end
        checks++; if (c_long - c_press != LC) begin errors++; $display("FAIL long_delay got %0d exp %0d", c_long - c_press, LC); end
        checks++; if (n_rel != 1)   begin errors++; $display("FAIL long_release_count got %0d exp 1", n_rel); end
`ifdef AUTO_REPEAT_EN
        checks++; if (n_rep != 1)   begin errors++; $display("FAIL repeat_count got %0d exp 1", n_rep); end
        checks++; if (c_rep - c_press != LC + RC) begin errors++; $display("FAIL repeat_delay got %0d exp %0d", c_rep - c_press, LC + RC); end
`else
        checks++; if (n_rep != 0)   begin errors++; $display("FAIL repeat_count got %0d exp 0", n_rep); end
`endif
        wait_cyc(2);
    endtask

    task automatic test_reset_midhold();
        int c_press, c_long, n_press, n_long, n_rel, n_other;
        c_press = -1; c_long = -1; n_press = 0; n_long = 0; n_rel = 0; n_other = 0;
        ev_ready = 1'b0;
        btn_db[1] = 1'b0; btn_db[2] = 1'b0; btn_db[3] = 1'b0;
        wait_cyc(5);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL midhold_queued valid got %b exp 1", ev_valid); end
        rst_n = 1'b0;
        btn_db[2] = 1'b1; btn_db[3] = 1'b1;
        #1;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midhold_async_clear valid got %b exp 0", ev_valid); end
        wait_cyc(2);
        checks++; if (any_held !== 1'b0) begin errors++; $display("FAIL midhold_held_in_reset got %b exp 0", any_held); end
        rst_n = 1'b1;
        ev_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            wait_cyc(1);
            if (ev_valid === 1'b1) begin
                if (ev_idx != 3'd1)       n_other++;
                else if (ev_type == 2'd0) begin n_press++; c_press = c; end
                else if (ev_type == 2'd2) begin n_long++; c_long = c; end
                else if (ev_type == 2'd1) n_rel++;
                else                      n_other++;
            end
            if (c == 26) btn_db[1] = 1'b1;
        end
        checks++; if (n_press != 1) begin errors++; $display("FAIL midhold_press_count got %0d exp 1", n_press); end
        checks++; if (n_long != 1)  begin errors++; $display("FAIL midhold_long_count got %0d exp 1", n_long); end
        checks++; if (c_long - c_press != LC) begin errors++; $display("FAIL midhold_long_delay got %0d exp %0d", c_long - c_press, LC); end
        checks++; if (n_rel != 1)   begin errors++; $display("FAIL midhold_release_count got %0d exp 1", n_rel); end
        checks++; if (n_other != 0) begin errors++; $display("FAIL midhold_stray_events got %0d exp 0", n_other); end
        wait_cyc(2);
    endtask

    task automatic test_random(int ncyc);
        int rdy_pct;
        rdy_pct = 80;
        for (int c = 0; c < ncyc; c++) begin
            wait_cyc(1);
            checks++;
            if (ev_valid !== (m_fifo.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, ev_valid, m_fifo.size() != 0);
            end
            if (m_fifo.size() != 0 && ev_valid === 1'b1) begin
                checks++;
                if ({ev_idx, ev_type} !== m_fifo[0]) begin
                    errors++; $display("FAIL rand_head cyc %0d got %b exp %b", c, {ev_idx, ev_type}, m_fifo[0]);
                end
            end
            checks++;
            if (ev_overflow !== m_ovf) begin
                errors++; $display("FAIL rand_ovf cyc %0d got %b exp %b", c, ev_overflow, m_ovf);
            end
            checks++;
            if (any_held !== m_any) begin
                errors++; $display("FAIL rand_held cyc %0d got %b exp %b", c, any_held, m_any);
            end
            if (c % 64 == 0) rdy_pct = int'($urandom_range(0, 3)) * 30;
            ev_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 23) == 0) btn_db[b] = ~btn_db[b];
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_round_robin();
        test_back_to_back();
        test_overflow();
        test_long_hold();
        test_reset_midhold();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
